// File: rtl/sdp_ram_pipelined_if.sv
`default_nettype none
// ============================================================================
// sdp_ram_pipelined_if : write/read bus of the pipelined simple dual-port RAM
// Rev 1.0
// ============================================================================
interface sdp_ram_pipelined_if #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 256,
  parameter int BYTE_W = 8
);
  localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NBYTES     = WIDTH / BYTE_W;

  logic                  ena;
  logic [NBYTES-1:0]     wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [WIDTH-1:0]      dia;
  logic                  enb;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [WIDTH-1:0]      dob;
  logic                  dob_valid;
  logic                  collision;

  modport master (
    output ena, wea, addra, dia, enb, addrb,
    input  dob, dob_valid, collision
  );

  modport slave (
    input  ena, wea, addra, dia, enb, addrb,
    output dob, dob_valid, collision
  );
endinterface
`default_nettype wire

// File: rtl/sdp_ram_pipelined.sv
`default_nettype none
// ============================================================================
// sdp_ram_pipelined : byte-enable SDP RAM with 1-3 stage valid-tracked read
// Rev 1.0
// ============================================================================
module sdp_ram_pipelined #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 256,
  parameter int BYTE_W       = 8,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 0
) (
  input  logic               clk,
  input  logic               rst,
  sdp_ram_pipelined_if.slave bus
);
  localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NBYTES     = WIDTH / BYTE_W;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  if ((WIDTH % BYTE_W) != 0) begin : g_chk_width
    $error("sdp_ram_pipelined: WIDTH must be a multiple of BYTE_W");
  end
  if ((READ_LATENCY < 1) || (READ_LATENCY > 3)) begin : g_chk_latency
    $error("sdp_ram_pipelined: READ_LATENCY must be 1, 2 or 3");
  end

  logic [WIDTH-1:0]        mem_q [DEPTH];
  logic [WIDTH-1:0]        data_q [READ_LATENCY];
  logic [READ_LATENCY-1:0] valid_q;
  logic                    collision_q;

  logic                    wr_ok;
  logic                    rd_ok;
  logic                    wr_en;
  logic                    collision_d;
  logic [WIDTH-1:0]        rd_word;
  logic [WIDTH-1:0]        rd_data_d;

  always_comb begin
    wr_ok       = ({1'b0, bus.addra} < DEPTH_EXT);
    rd_ok       = ({1'b0, bus.addrb} < DEPTH_EXT);
    wr_en       = bus.ena && (|bus.wea) && wr_ok;
    collision_d = bus.ena && (|bus.wea) && bus.enb && (bus.addra == bus.addrb);
    rd_word     = rd_ok ? mem_q[bus.addrb] : '0;
    rd_data_d   = rd_word;
    // Write-first bypass: the enabled lanes of the incoming write replace the stored bytes.
    if ((WRITE_FIRST != 0) && wr_en && (bus.addra == bus.addrb)) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (bus.wea[i]) begin
          rd_data_d[i*BYTE_W +: BYTE_W] = bus.dia[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (bus.wea[i]) begin
          mem_q[bus.addra][i*BYTE_W +: BYTE_W] <= bus.dia[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      collision_q <= 1'b0;
      for (int s = 0; s < READ_LATENCY; s++) begin
        data_q[s] <= '0;
      end
    end else begin
      valid_q[0]  <= bus.enb;
      collision_q <= collision_d;
      if (bus.enb) begin
        data_q[0] <= rd_data_d;
      end
      // Later stages only advance behind a valid word so dob holds between reads.
      for (int s = 1; s < READ_LATENCY; s++) begin
        valid_q[s] <= valid_q[s-1];
        if (valid_q[s-1]) begin
          data_q[s] <= data_q[s-1];
        end
      end
    end
  end

  assign bus.dob       = data_q[READ_LATENCY-1];
  assign bus.dob_valid = valid_q[READ_LATENCY-1];
  assign bus.collision = collision_q;

endmodule
`default_nettype wire

// File: tb/tb_sdp_ram_pipelined.sv
`default_nettype none
// ============================================================================
// tb_sdp_ram_pipelined : directed bench over three latency/collision variants
// Rev 1.0
// ============================================================================
module tb_sdp_ram_pipelined;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sdp_ram_pipelined_if #(.WIDTH(32), .DEPTH(12), .BYTE_W(8)) if_a ();
  sdp_ram_pipelined_if #(.WIDTH(32), .DEPTH(12), .BYTE_W(8)) if_b ();
  sdp_ram_pipelined_if #(.WIDTH(32), .DEPTH(12), .BYTE_W(8)) if_c ();

  // All three variants see identical stimulus.
  assign if_b.ena   = if_a.ena;
  assign if_b.wea   = if_a.wea;
  assign if_b.addra = if_a.addra;
  assign if_b.dia   = if_a.dia;
  assign if_b.enb   = if_a.enb;
  assign if_b.addrb = if_a.addrb;
  assign if_c.ena   = if_a.ena;
  assign if_c.wea   = if_a.wea;
  assign if_c.addra = if_a.addra;
  assign if_c.dia   = if_a.dia;
  assign if_c.enb   = if_a.enb;
  assign if_c.addrb = if_a.addrb;

  sdp_ram_pipelined #(.WIDTH(32), .DEPTH(12), .BYTE_W(8), .READ_LATENCY(2), .WRITE_FIRST(0))
    u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
  sdp_ram_pipelined #(.WIDTH(32), .DEPTH(12), .BYTE_W(8), .READ_LATENCY(3), .WRITE_FIRST(1))
    u_dut_b (.clk(clk), .rst(rst), .bus(if_b));
  sdp_ram_pipelined #(.WIDTH(32), .DEPTH(12), .BYTE_W(8), .READ_LATENCY(1), .WRITE_FIRST(1))
    u_dut_c (.clk(clk), .rst(rst), .bus(if_c));

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_a.ena   = 1'b0;
    if_a.wea   = 4'h0;
    if_a.addra = 4'h0;
    if_a.dia   = 32'h0;
    if_a.enb   = 1'b0;
    if_a.addrb = 4'h0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] we, input logic [31:0] d);
    if_a.ena   = 1'b1;
    if_a.wea   = we;
    if_a.addra = a;
    if_a.dia   = d;
    tick();
    idle();
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "/a_dob"},   if_a.dob, 32'h0);
    check_val({tag, "/a_valid"}, 32'(if_a.dob_valid), 32'd0);
    check_val({tag, "/b_dob"},   if_b.dob, 32'h0);
    check_val({tag, "/b_valid"}, 32'(if_b.dob_valid), 32'd0);
    check_val({tag, "/c_dob"},   if_c.dob, 32'h0);
    check_val({tag, "/c_valid"}, 32'(if_c.dob_valid), 32'd0);
  endtask

  // One read at edge t; any write for the same edge is set up by the caller.
  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp_rf,
                        input logic [31:0] exp_wf, input logic exp_col);
    if_a.enb   = 1'b1;
    if_a.addrb = a;
    tick();
    idle();
    check_val({tag, "/t0_c_valid"}, 32'(if_c.dob_valid), 32'd1);
    check_val({tag, "/t0_c_dob"},   if_c.dob, exp_wf);
    check_val({tag, "/t0_a_valid"}, 32'(if_a.dob_valid), 32'd0);
    check_val({tag, "/t0_b_valid"}, 32'(if_b.dob_valid), 32'd0);
    check_val({tag, "/t0_a_col"},   32'(if_a.collision), 32'(exp_col));
    check_val({tag, "/t0_b_col"},   32'(if_b.collision), 32'(exp_col));
    tick();
    check_val({tag, "/t1_a_valid"}, 32'(if_a.dob_valid), 32'd1);
    check_val({tag, "/t1_a_dob"},   if_a.dob, exp_rf);
    check_val({tag, "/t1_c_valid"}, 32'(if_c.dob_valid), 32'd0);
    check_val({tag, "/t1_c_hold"},  if_c.dob, exp_wf);
    check_val({tag, "/t1_b_valid"}, 32'(if_b.dob_valid), 32'd0);
    check_val({tag, "/t1_a_col"},   32'(if_a.collision), 32'd0);
    tick();
    check_val({tag, "/t2_b_valid"}, 32'(if_b.dob_valid), 32'd1);
    check_val({tag, "/t2_b_dob"},   if_b.dob, exp_wf);
    check_val({tag, "/t2_a_valid"}, 32'(if_a.dob_valid), 32'd0);
    check_val({tag, "/t2_a_hold"},  if_a.dob, exp_rf);
    tick();
    check_val({tag, "/t3_b_valid"}, 32'(if_b.dob_valid), 32'd0);
    check_val({tag, "/t3_b_hold"},  if_b.dob, exp_wf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    check_val("reset/a_col", 32'(if_a.collision), 32'd0);
    check_val("reset/b_col", 32'(if_b.collision), 32'd0);
    rst = 1'b0;

    wr(4'd3, 4'hF, 32'h0000_0000);
    wr(4'd5, 4'hF, 32'hDEAD_BEEF);
    wr(4'd9, 4'hF, 32'h1122_3344);
    wr(4'd9, 4'b0101, 32'hAABB_CCDD);
    wr(4'd7, 4'hF, 32'h7777_7777);

    rd_chk("rd5", 4'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    rd_chk("be9", 4'd9, 32'h11BB_33DD, 32'h11BB_33DD, 1'b0);

    if_a.ena   = 1'b1;
    if_a.wea   = 4'hF;
    if_a.addra = 4'd3;
    if_a.dia   = 32'hCAFE_F00D;
    rd_chk("col3", 4'd3, 32'h0000_0000, 32'hCAFE_F00D, 1'b1);
    rd_chk("rd3",  4'd3, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);

    if_a.ena   = 1'b1;
    if_a.wea   = 4'b1000;
    if_a.addra = 4'd9;
    if_a.dia   = 32'h5500_0000;
    rd_chk("colbe9", 4'd9, 32'h11BB_33DD, 32'h55BB_33DD, 1'b1);

    wr(4'd13, 4'hF, 32'hFFFF_FFFF);
    rd_chk("oor13", 4'd13, 32'h0, 32'h0, 1'b0);

    // Write and read presented while in reset must both be ignored.
    rst        = 1'b1;
    if_a.ena   = 1'b1;
    if_a.wea   = 4'hF;
    if_a.addra = 4'd7;
    if_a.dia   = 32'h1234_5678;
    if_a.enb   = 1'b1;
    if_a.addrb = 4'd7;
    tick();
    idle();
    rst = 1'b0;
    check_all_zero("rstgate");
    tick();
    check_val("rstgate/c_valid", 32'(if_c.dob_valid), 32'd0);
    rd_chk("rstgate7", 4'd7, 32'h7777_7777, 32'h7777_7777, 1'b0);

    if_a.enb   = 1'b1;
    if_a.addrb = 4'd5;
    tick();
    if_a.addrb = 4'd9;
    tick();
    check_val("midrst/a_valid", 32'(if_a.dob_valid), 32'd1);
    check_val("midrst/a_dob",   if_a.dob, 32'hDEAD_BEEF);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midrst");
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val("midrst/b_valid", 32'(if_b.dob_valid), 32'd0);
      check_val("midrst/b_dob",   if_b.dob, 32'h0);
      check_val("midrst/a_valid_after", 32'(if_a.dob_valid), 32'd0);
    end
    rd_chk("post_rst5", 4'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);

    for (int k = 0; k < 8; k++) begin
      wr(k[3:0], 4'hF, 32'h100 + k);
    end
    for (int i = 0; i < 12; i++) begin
      if (i < 8) begin
        if_a.enb   = 1'b1;
        if_a.addrb = i[3:0];
      end else begin
        idle();
      end
      tick();
      check_val("stream/b_valid", 32'(if_b.dob_valid), ((i >= 2) && (i < 10)) ? 32'd1 : 32'd0);
      if (i >= 2) begin
        check_val("stream/b_dob", if_b.dob, 32'h100 + ((i - 2 > 7) ? 7 : i - 2));
      end
      check_val("stream/a_valid", 32'(if_a.dob_valid), ((i >= 1) && (i < 9)) ? 32'd1 : 32'd0);
      if (i >= 1) begin
        check_val("stream/a_dob", if_a.dob, 32'h100 + ((i - 1 > 7) ? 7 : i - 1));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
